lock_sig_avg: RTL and testbench

Front-end stage that feeds the dynamic lockbox. It turns the raw ADC sample stream into one averaged, offset-binary lock-signal value per averaging block.
- For each calibration pulse, it waits a programmed delay and picks one lane of the 16-sample ADC word.
- It takes the maximum of that lane over a short window to absorb timing jitter.
- It averages 2^L such per-pulse values, then emits the result with a one-cycle valid strobe for the lock FSM.

---
 rtl/lock_sig_avg.sv | 256 +++++++++++++++++++++++++
 tb/tb_lock_sig_avg.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_sig_avg.sv
// lock_sig_avg: turns the raw ADC word stream into one averaged,
// offset-binary lock-signal value per averaging block.
//
// For every accepted calibration pulse the block waits D cycles, then takes
// the unsigned maximum of one offset-binary lane over W consecutive samples.
// 2^L of those per-pulse maxima are summed and shifted down by L to produce
// avg_out with a one-cycle avg_valid strobe.
//
// Config write bus layout on gpio_in:
//   [31]    write strobe (a register loads while this is high and the
//           address matches)
//   [30:24] register address
//   [23:16] reserved
//   [15:0]  write data
// Registers: BASE_ADDR+0 delay_cycles[15:0], +1 lane_sel[3:0],
//            +2 log2_avgs[3:0], +3 window_len[7:0].
module lock_sig_avg #(
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned LANES        = 16,
  parameter int unsigned SAMPLE_W     = 16,
  parameter int unsigned MAX_LOG2_AVG = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               gpio_in,
  input  logic [LANES*SAMPLE_W-1:0] adc_data_in,
  input  logic                      pulse_trig,
  input  logic                      enable,
  output logic [SAMPLE_W-1:0]       pulse_val,
  output logic                      pulse_valid,
  output logic [SAMPLE_W-1:0]       avg_out,
  output logic                      avg_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned ACC_W  = SAMPLE_W + MAX_LOG2_AVG;
  localparam int unsigned CNT_W  = MAX_LOG2_AVG + 1;

  localparam logic [3:0]          MAX_L    = 4'(MAX_LOG2_AVG);
  localparam logic [SAMPLE_W-1:0] SIGN_BIT = {1'b1, {(SAMPLE_W-1){1'b0}}};

  localparam logic [6:0] ADDR_DELAY = 7'(BASE_ADDR);
  localparam logic [6:0] ADDR_LANE  = 7'(BASE_ADDR + 1);
  localparam logic [6:0] ADDR_LOG2  = 7'(BASE_ADDR + 2);
  localparam logic [6:0] ADDR_WIN   = 7'(BASE_ADDR + 3);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_WINDOW = 2'd2;

  // Config bus fields
  logic        cfg_wr;
  logic [6:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        unused_gpio_bits;

  assign cfg_wr           = gpio_in[31];
  assign cfg_addr         = gpio_in[30:24];
  assign cfg_data         = gpio_in[15:0];
  assign unused_gpio_bits = ^gpio_in[23:16];

  // Config registers
  logic [15:0]       cfg_delay_q, cfg_delay_d;
  logic [LANE_W-1:0] cfg_lane_q,  cfg_lane_d;
  logic [3:0]        cfg_log2_q,  cfg_log2_d;
  logic [7:0]        cfg_win_q,   cfg_win_d;

  // Capture FSM and per-pulse latched settings
  logic [1:0]        state_q,   state_d;
  logic [15:0]       dly_cnt_q, dly_cnt_d;
  logic [7:0]        win_cnt_q, win_cnt_d;
  logic [7:0]        win_len_q, win_len_d;
  logic [LANE_W-1:0] lane_q,    lane_d;
  logic [3:0]        log2_q,    log2_d;
  logic [SAMPLE_W-1:0] max_q,   max_d;

  // Averaging state
  logic [ACC_W-1:0]  acc_q,       acc_d;
  logic [CNT_W-1:0]  pulse_cnt_q, pulse_cnt_d;

  // Output registers
  logic [SAMPLE_W-1:0] pulse_val_q,   pulse_val_d;
  logic                pulse_valid_q, pulse_valid_d;
  logic [SAMPLE_W-1:0] avg_out_q,     avg_out_d;
  logic                avg_valid_q,   avg_valid_d;
  logic                overrun_q,     overrun_d;

  // Derived values
  logic [15:0]         eff_delay;
  logic [7:0]          eff_win;
  logic [3:0]          eff_log2;
  logic [SAMPLE_W-1:0] lane_words [LANES];
  logic [SAMPLE_W-1:0] sample_off;
  logic [SAMPLE_W-1:0] win_max;
  logic [CNT_W-1:0]    blk_len;
  logic [CNT_W-1:0]    pulse_cnt_inc;
  logic [ACC_W-1:0]    acc_sum;
  logic                win_last;

  // Config register write decode: each register loads when its address is strobed
  always_comb begin
    cfg_delay_d = cfg_delay_q;
    cfg_lane_d  = cfg_lane_q;
    cfg_log2_d  = cfg_log2_q;
    cfg_win_d   = cfg_win_q;
    if (cfg_wr) begin
      if (cfg_addr == ADDR_DELAY) cfg_delay_d = cfg_data;
      if (cfg_addr == ADDR_LANE)  cfg_lane_d  = cfg_data[LANE_W-1:0];
      if (cfg_addr == ADDR_LOG2)  cfg_log2_d  = cfg_data[3:0];
      if (cfg_addr == ADDR_WIN)   cfg_win_d   = cfg_data[7:0];
    end
  end

  // Effective settings: zero delay/window act as one, averaging count clamps
  always_comb begin
    eff_delay = (cfg_delay_q == 16'd0) ? 16'd1 : cfg_delay_q;
    eff_win   = (cfg_win_q == 8'd0) ? 8'd1 : cfg_win_q;
    eff_log2  = (cfg_log2_q > MAX_L) ? MAX_L : cfg_log2_q;
  end

  // Split the ADC word into lanes so the latched lane index can pick one
  always_comb begin
    for (int i = 0; i < int'(LANES); i++) begin
      lane_words[i] = adc_data_in[i*SAMPLE_W +: SAMPLE_W];
    end
  end

  // Window datapath: offset-binary conversion, running max, block arithmetic
  always_comb begin
    sample_off    = lane_words[lane_q] ^ SIGN_BIT;
    win_max       = ((win_cnt_q == 8'd0) || (sample_off > max_q)) ? sample_off : max_q;
    win_last      = (win_cnt_q == (win_len_q - 8'd1));
    blk_len       = CNT_W'(1) << log2_q;
    pulse_cnt_inc = pulse_cnt_q + CNT_W'(1);
    acc_sum       = acc_q + ACC_W'(win_max);
  end

  // Capture FSM, accumulator and output strobes
  always_comb begin
    state_d       = state_q;
    dly_cnt_d     = dly_cnt_q;
    win_cnt_d     = win_cnt_q;
    win_len_d     = win_len_q;
    lane_d        = lane_q;
    log2_d        = log2_q;
    max_d         = max_q;
    acc_d         = acc_q;
    pulse_cnt_d   = pulse_cnt_q;
    pulse_val_d   = pulse_val_q;
    pulse_valid_d = 1'b0;
    avg_out_d     = avg_out_q;
    avg_valid_d   = 1'b0;
    overrun_d     = overrun_q;

    if (!enable) begin
      state_d     = ST_IDLE;
      acc_d       = '0;
      pulse_cnt_d = '0;
      overrun_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pulse_trig) begin
            dly_cnt_d = eff_delay - 16'd1;
            win_len_d = eff_win;
            lane_d    = cfg_lane_q;
            win_cnt_d = 8'd0;
            if (pulse_cnt_q == '0) log2_d = eff_log2;
            state_d   = (eff_delay == 16'd1) ? ST_WINDOW : ST_DELAY;
          end
        end

        ST_DELAY: begin
          if (pulse_trig) overrun_d = 1'b1;
          dly_cnt_d = dly_cnt_q - 16'd1;
          if (dly_cnt_q == 16'd1) state_d = ST_WINDOW;
        end

        ST_WINDOW: begin
          if (pulse_trig) overrun_d = 1'b1;
          max_d     = win_max;
          win_cnt_d = win_cnt_q + 8'd1;
          if (win_last) begin
            state_d       = ST_IDLE;
            pulse_val_d   = win_max;
            pulse_valid_d = 1'b1;
            if (pulse_cnt_inc == blk_len) begin
              avg_out_d   = SAMPLE_W'(acc_sum >> log2_q);
              avg_valid_d = 1'b1;
              acc_d       = '0;
              pulse_cnt_d = '0;
            end else begin
              acc_d       = acc_sum;
              pulse_cnt_d = pulse_cnt_inc;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // All state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_delay_q   <= '0;
      cfg_lane_q    <= '0;
      cfg_log2_q    <= '0;
      cfg_win_q     <= '0;
      state_q       <= ST_IDLE;
      dly_cnt_q     <= '0;
      win_cnt_q     <= '0;
      win_len_q     <= '0;
      lane_q        <= '0;
      log2_q        <= '0;
      max_q         <= '0;
      acc_q         <= '0;
      pulse_cnt_q   <= '0;
      pulse_val_q   <= '0;
      pulse_valid_q <= 1'b0;
      avg_out_q     <= '0;
      avg_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      cfg_delay_q   <= cfg_delay_d;
      cfg_lane_q    <= cfg_lane_d;
      cfg_log2_q    <= cfg_log2_d;
      cfg_win_q     <= cfg_win_d;
      state_q       <= state_d;
      dly_cnt_q     <= dly_cnt_d;
      win_cnt_q     <= win_cnt_d;
      win_len_q     <= win_len_d;
      lane_q        <= lane_d;
      log2_q        <= log2_d;
      max_q         <= max_d;
      acc_q         <= acc_d;
      pulse_cnt_q   <= pulse_cnt_d;
      pulse_val_q   <= pulse_val_d;
      pulse_valid_q <= pulse_valid_d;
      avg_out_q     <= avg_out_d;
      avg_valid_q   <= avg_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign pulse_val   = pulse_val_q;
  assign pulse_valid = pulse_valid_q;
  assign avg_out     = avg_out_q;
  assign avg_valid   = avg_valid_q;
  assign busy        = (state_q != ST_IDLE);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_lock_sig_avg.sv
// Testbench for lock_sig_avg: directed pulses with hand-computed results.
// Expected strobes (value and the clock edge they are registered on) are
// queued when a pulse is issued; a negedge monitor pops and compares them.
module tb_lock_sig_avg;

  logic         clk;
  logic         rst;
  logic [31:0]  gpio_in;
  logic [255:0] adc_data_in;
  logic         pulse_trig;
  logic         enable;
  logic [15:0]  pulse_val;
  logic         pulse_valid;
  logic [15:0]  avg_out;
  logic         avg_valid;
  logic         busy;
  logic         overrun;

  typedef struct {
    logic [15:0] val;
    int          edgeNum;
  } exp_t;

  exp_t pulseQ[$];
  exp_t avgQ[$];
  exp_t monE;

  int vecCount = 0;
  int errCount = 0;
  int cyc = 0;

  logic [15:0] seq [0:7];
  logic [15:0] fillVal;

  lock_sig_avg dut (
    .clk         (clk),
    .rst         (rst),
    .gpio_in     (gpio_in),
    .adc_data_in (adc_data_in),
    .pulse_trig  (pulse_trig),
    .enable      (enable),
    .pulse_val   (pulse_val),
    .pulse_valid (pulse_valid),
    .avg_out     (avg_out),
    .avg_valid   (avg_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  // Free-running clock and an edge counter used to time-stamp strobes
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Hard time limit so the bench can never hang
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required normal finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic stepClk;
    @(posedge clk);
    #1;
  endtask

  task automatic writeCfg(input int addr, input int data);
    gpio_in = {1'b1, 7'(addr), 8'h00, 16'(data)};
    stepClk;
    gpio_in = 32'h0;
  endtask

  function automatic logic [255:0] mkWord(input int lane, input logic [15:0] v);
    logic [255:0] w;
    for (int i = 0; i < 16; i++) w[i*16 +: 16] = (i == lane) ? v : fillVal;
    return w;
  endfunction

  // Issue one pulse: seq[k] is the selected lane's raw value at edge t0+k.
  // Queues the expected strobes and checks busy after every edge.
  task automatic applyStimulus(input int lane, input int dEff, input int wEff, input int retrig,
                               input logic [15:0] expPulse, input bit doAvg, input logic [15:0] expAvg);
    int nCyc;
    int t0;
    exp_t e;
    nCyc = dEff + wEff - 1;
    pulse_trig  = 1'b1;
    adc_data_in = mkWord(lane, seq[0]);
    stepClk;
    t0 = cyc;
    e.val = expPulse;
    e.edgeNum = t0 + nCyc;
    pulseQ.push_back(e);
    if (doAvg) begin
      e.val = expAvg;
      avgQ.push_back(e);
    end
    #3;
    checkOutput("busy_start", 32'(busy), 32'd1);
    for (int k = 1; k <= nCyc; k++) begin
      pulse_trig  = (k == retrig);
      adc_data_in = mkWord(lane, seq[k]);
      stepClk;
      #3;
      checkOutput("busy_run", 32'(busy), (k < nCyc) ? 32'd1 : 32'd0);
    end
    pulse_trig = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) stepClk;
  endtask

  // Scoreboard monitor: every strobe must match the head of its queue
  always @(negedge clk) begin
    if (rst) begin
      if (pulse_valid) begin
        if (pulseQ.size() == 0) begin
          vecCount++;
          errCount++;
          $display("[TB] FAIL unexpected_pulse: actual pulse_val=%0h, required no strobe (t=%0t)", pulse_val, $time);
        end else begin
          monE = pulseQ.pop_front();
          checkOutput("pulse_val", 32'(pulse_val), 32'(monE.val));
          checkOutput("pulse_edge", 32'(cyc), 32'(monE.edgeNum));
        end
      end
      if (avg_valid) begin
        if (avgQ.size() == 0) begin
          vecCount++;
          errCount++;
          $display("[TB] FAIL unexpected_avg: actual avg_out=%0h, required no strobe (t=%0t)", avg_out, $time);
        end else begin
          monE = avgQ.pop_front();
          checkOutput("avg_out", 32'(avg_out), 32'(monE.val));
          checkOutput("avg_edge", 32'(cyc), 32'(monE.edgeNum));
        end
      end
    end
  end

  // Directed test sequence
  initial begin
    logic [15:0] raw3 [0:4];
    logic [15:0] exp3 [0:4];
    rst = 1'b0;
    enable = 1'b0;
    gpio_in = 32'h0;
    adc_data_in = '0;
    pulse_trig = 1'b0;
    fillVal = 16'h7FFF;
    for (int i = 0; i < 8; i++) seq[i] = 16'h0000;

    // Reset state
    #8;
    checkOutput("rst_pulse_val", 32'(pulse_val), 32'h0);
    checkOutput("rst_pulse_valid", 32'(pulse_valid), 32'h0);
    checkOutput("rst_avg_out", 32'(avg_out), 32'h0);
    checkOutput("rst_avg_valid", 32'(avg_valid), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_overrun", 32'(overrun), 32'h0);
    #4 rst = 1'b1;
    stepClk;
    enable = 1'b1;

    // Test 1: D=3 W=1 L=0 lane 2, only edge t0+3 is sampled
    writeCfg(0, 3); writeCfg(1, 2); writeCfg(2, 0); writeCfg(3, 1);
    seq[0] = 16'h0000; seq[1] = 16'h2000; seq[2] = 16'h3000; seq[3] = 16'h1000;
    applyStimulus(2, 3, 1, -1, 16'h9000, 1'b1, 16'h9000);
    idle(2);

    // Test 2: D=2 W=4 lane 0, signed window -100,50,20,-5 -> max 0x8032
    writeCfg(0, 2); writeCfg(1, 0); writeCfg(3, 4);
    seq[0] = 16'h7000; seq[1] = 16'h7000; seq[2] = 16'hFF9C;
    seq[3] = 16'h0032; seq[4] = 16'h0014; seq[5] = 16'hFFFB;
    applyStimulus(0, 2, 4, -1, 16'h8032, 1'b1, 16'h8032);
    idle(2);

    // Test 3: L=2, four pulses average to 0x9006, fifth opens a new block
    writeCfg(2, 2); writeCfg(3, 1);
    raw3[0] = 16'h1000; raw3[1] = 16'h1004; raw3[2] = 16'h1008; raw3[3] = 16'h100C; raw3[4] = 16'h1000;
    exp3[0] = 16'h9000; exp3[1] = 16'h9004; exp3[2] = 16'h9008; exp3[3] = 16'h900C; exp3[4] = 16'h9000;
    for (int p = 0; p < 5; p++) begin
      seq[0] = 16'h7000; seq[1] = 16'h7000; seq[2] = raw3[p];
      applyStimulus(0, 2, 1, -1, exp3[p], (p == 3), 16'h9006);
      idle(2);
    end

    // Test 4: retrigger inside the window sets overrun, no extra capture
    enable = 1'b0;
    stepClk;
    enable = 1'b1;
    writeCfg(2, 0); writeCfg(0, 1); writeCfg(3, 3);
    seq[0] = 16'h0040; seq[1] = 16'h0010; seq[2] = 16'h0030; seq[3] = 16'h0020;
    applyStimulus(0, 1, 3, 2, 16'h8030, 1'b1, 16'h8030);
    checkOutput("overrun_set", 32'(overrun), 32'h1);
    idle(3);
    checkOutput("overrun_sticky", 32'(overrun), 32'h1);
    enable = 1'b0;
    stepClk;
    #3;
    checkOutput("overrun_cleared", 32'(overrun), 32'h0);
    enable = 1'b1;

    // Test 5: L=2, enable dropped after two pulses discards the partial block
    writeCfg(2, 2); writeCfg(0, 2); writeCfg(3, 1);
    for (int p = 0; p < 2; p++) begin
      seq[0] = 16'h7000; seq[1] = 16'h7000; seq[2] = 16'h2000;
      applyStimulus(0, 2, 1, -1, 16'hA000, 1'b0, 16'h0000);
      idle(1);
    end
    enable = 1'b0;
    stepClk;
    #3;
    checkOutput("abort_busy", 32'(busy), 32'h0);
    checkOutput("abort_avg_hold", 32'(avg_out), 32'h8030);
    checkOutput("abort_pulse_hold", 32'(pulse_val), 32'hA000);
    enable = 1'b1;
    for (int p = 0; p < 4; p++) begin
      seq[0] = 16'h7000; seq[1] = 16'h7000; seq[2] = (p == 3) ? 16'h0004 : 16'h0000;
      applyStimulus(0, 2, 1, -1, (p == 3) ? 16'h8004 : 16'h8000, (p == 3), 16'h8001);
      idle(2);
    end

    // Test 6a: delay_cycles=0 behaves as one cycle
    writeCfg(0, 0); writeCfg(2, 0);
    seq[0] = 16'h0100; seq[1] = 16'h0200; seq[2] = 16'h0300;
    applyStimulus(0, 1, 1, -1, 16'h8200, 1'b1, 16'h8200);
    idle(2);

    // Test 6b: log2_avgs=15 clamps to 8, 256 pulses of 0x8000+i average to 0x807F
    writeCfg(2, 15);
    for (int i = 0; i < 256; i++) begin
      seq[0] = 16'h7000; seq[1] = 16'(i);
      applyStimulus(0, 1, 1, -1, 16'h8000 | 16'(i), (i == 255), 16'h807F);
    end
    idle(2);

    // Test 6c: lane 15 extremes
    writeCfg(2, 0); writeCfg(1, 15);
    fillVal = 16'h7FFF;
    seq[0] = 16'h0000; seq[1] = 16'h8000;
    applyStimulus(15, 1, 1, -1, 16'h0000, 1'b1, 16'h0000);
    idle(2);
    fillVal = 16'h0000;
    seq[0] = 16'h0000; seq[1] = 16'h7FFF;
    applyStimulus(15, 1, 1, -1, 16'hFFFF, 1'b1, 16'hFFFF);
    idle(2);

    // Test 6d: asynchronous reset in the middle of DELAY
    fillVal = 16'h7FFF;
    writeCfg(0, 5);
    pulse_trig = 1'b1;
    stepClk;
    pulse_trig = 1'b0;
    stepClk;
    pulse_trig = 1'b1;
    stepClk;
    pulse_trig = 1'b0;
    #3;
    checkOutput("pre_rst_busy", 32'(busy), 32'h1);
    checkOutput("pre_rst_overrun", 32'(overrun), 32'h1);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_rst_pulse_val", 32'(pulse_val), 32'h0);
    checkOutput("async_rst_avg_out", 32'(avg_out), 32'h0);
    checkOutput("async_rst_busy", 32'(busy), 32'h0);
    checkOutput("async_rst_overrun", 32'(overrun), 32'h0);
    checkOutput("async_rst_pulse_valid", 32'(pulse_valid), 32'h0);
    checkOutput("async_rst_avg_valid", 32'(avg_valid), 32'h0);
    stepClk;
    #2 rst = 1'b1;
    idle(6);

    // After reset the config is back to zero: D=1, W=1, lane 0, L=0
    seq[0] = 16'h1234; seq[1] = 16'h0001;
    applyStimulus(0, 1, 1, -1, 16'h8001, 1'b1, 16'h8001);
    idle(4);

    checkOutput("pulseQ_left", 32'(pulseQ.size()), 32'h0);
    checkOutput("avgQ_left", 32'(avgQ.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
